// File: rtl/sram_pkg.sv
// sram_pkg: shared definitions for the SRAM responder slice.
//   DWIDTH_DEF / AWIDTH_DEF : default data and address widths
//   WCNT_W                  : width of the read wait-state counter (RD_WAIT 0..7)
//   state_t                 : responder FSM states
package sram_pkg;

    localparam int DWIDTH_DEF = 16;
    localparam int AWIDTH_DEF = 12;
    localparam int WCNT_W     = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RWAIT = 2'd1,
        RRESP = 2'd2,
        WRESP = 2'd3
    } state_t;

endpackage

// File: rtl/sram_array.sv
// sram_array: DEPTH x DWIDTH word storage, synchronous write, registered read.
// Contents and the read register are not reset.
// Ports:
//   clk   : clock, rising edge
//   we    : write enable, writes wdata to mem[waddr] at the edge
//   waddr : write word index
//   wdata : write data
//   re    : read enable, captures mem[raddr] into rdata at the edge
//   raddr : read word index
//   rdata : registered read data, holds between reads
module sram_array #(
    parameter int DWIDTH = 16,
    parameter int DEPTH  = 4096,
    parameter int IW     = 12
) (
    input  logic              clk,
    input  logic              we,
    input  logic [IW-1:0]     waddr,
    input  logic [DWIDTH-1:0] wdata,
    input  logic              re,
    input  logic [IW-1:0]     raddr,
    output logic [DWIDTH-1:0] rdata
);

    logic [DWIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/sram_responder.sv
// sram_responder: memory-side responder for the datapath memory bus.
// Serves level-held read/write requests from an internal SRAM after RD_WAIT
// wait states; returns read data with a one-cycle o_rvalid and writes with a
// one-cycle o_wack. Out-of-range accesses (addr >= DEPTH) complete with normal
// timing and pulse o_err alongside the response.
//
// Request protocol: i_read / i_write are levels sampled only at a rising edge
// while the FSM is IDLE (o_busy low). That edge is the acceptance edge; the
// address and write data are latched there and later changes are ignored.
// Each acceptance produces exactly one o_rvalid or o_wack pulse. A request
// still held when the FSM returns to IDLE is accepted again. Write beats read.
//
// Optional build macro: SRAM_STATS_EN adds o_rd_cnt / o_wr_cnt, saturating
// counts of accepted reads and writes, cleared by reset.
//
// Ports:
//   clk      : clock, rising edge
//   i_rst_n  : asynchronous active-low reset
//   i_read   : read request (level)
//   i_write  : write request (level)
//   i_addr   : request address
//   i_wdata  : write data
//   o_rdata  : read data, holds last read value
//   o_rvalid : one-cycle pulse, o_rdata valid
//   o_wack   : one-cycle pulse, write committed
//   o_busy   : high while the FSM is not IDLE
//   o_err    : one-cycle pulse, out-of-range access
//   o_rd_cnt : (SRAM_STATS_EN) accepted read count
//   o_wr_cnt : (SRAM_STATS_EN) accepted write count
module sram_responder
    import sram_pkg::*;
#(
    parameter int DWIDTH  = DWIDTH_DEF,
    parameter int AWIDTH  = AWIDTH_DEF,
    parameter int DEPTH   = 4096,
    parameter int RD_WAIT = 1
) (
    input  logic              clk,
    input  logic              i_rst_n,
    input  logic              i_read,
    input  logic              i_write,
    input  logic [AWIDTH-1:0] i_addr,
    input  logic [DWIDTH-1:0] i_wdata,
    output logic [DWIDTH-1:0] o_rdata,
    output logic              o_rvalid,
    output logic              o_wack,
    output logic              o_busy,
    output logic              o_err
`ifdef SRAM_STATS_EN
    ,
    output logic [15:0]       o_rd_cnt,
    output logic [15:0]       o_wr_cnt
`endif
);

    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AWIDTH:0] DEPTH_L = DEPTH[AWIDTH:0];

    // FSM state is kept as a named internal signal so checkers can bind to it.
    state_t              state;
    state_t              state_nx;
    logic [WCNT_W-1:0]   wcnt;
    logic [WCNT_W-1:0]   wcnt_nx;
    logic [IW-1:0]       addr_q;
    logic                oor_q;

    logic                in_range;
    logic                acc_wr;
    logic                acc_rd;
    logic                arr_we;
    logic                arr_re;
    logic [IW-1:0]       arr_raddr;
    logic [DWIDTH-1:0]   arr_rdata;

    assign in_range = ({1'b0, i_addr} < DEPTH_L);

    always_comb begin
        state_nx  = state;
        wcnt_nx   = wcnt;
        acc_wr    = 1'b0;
        acc_rd    = 1'b0;
        arr_re    = 1'b0;
        arr_raddr = addr_q;
        case (state)
            IDLE: begin
                if (i_write) begin
                    acc_wr   = 1'b1;
                    state_nx = WRESP;
                end else if (i_read) begin
                    acc_rd = 1'b1;
                    if (RD_WAIT == 0) begin
                        // Zero wait states: sample the array at the acceptance
                        // edge straight from the request address.
                        arr_raddr = i_addr[IW-1:0];
                        arr_re    = in_range;
                        state_nx  = RRESP;
                    end else begin
                        wcnt_nx  = WCNT_W'(RD_WAIT - 1);
                        state_nx = RWAIT;
                    end
                end
            end
            RWAIT: begin
                if (wcnt == '0) begin
                    arr_re   = ~oor_q;
                    state_nx = RRESP;
                end else begin
                    wcnt_nx = wcnt - WCNT_W'(1);
                end
            end
            RRESP:   state_nx = IDLE;
            WRESP:   state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Out-of-range writes leave the array untouched.
    assign arr_we = acc_wr & in_range;
    assign o_busy = (state != IDLE);

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wcnt     <= '0;
            addr_q   <= '0;
            oor_q    <= 1'b0;
            o_rdata  <= '0;
            o_rvalid <= 1'b0;
            o_wack   <= 1'b0;
            o_err    <= 1'b0;
        end else begin
            wcnt <= wcnt_nx;
            if (acc_rd) begin
                addr_q <= i_addr[IW-1:0];
                oor_q  <= ~in_range;
            end
            // Write is committed at the acceptance edge, so the ack follows
            // immediately; the read response is issued on the edge leaving RRESP.
            o_wack   <= acc_wr;
            o_rvalid <= (state == RRESP);
            o_err    <= (acc_wr & ~in_range) | ((state == RRESP) & oor_q);
            if (state == RRESP) begin
                o_rdata <= oor_q ? '0 : arr_rdata;
            end
        end
    end

`ifdef SRAM_STATS_EN
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_rd_cnt <= '0;
            o_wr_cnt <= '0;
        end else begin
            if (acc_rd && (o_rd_cnt != 16'hFFFF)) begin
                o_rd_cnt <= o_rd_cnt + 16'd1;
            end
            if (acc_wr && (o_wr_cnt != 16'hFFFF)) begin
                o_wr_cnt <= o_wr_cnt + 16'd1;
            end
        end
    end
`else
    // Statistics counters are not built.
`endif

    sram_array #(
        .DWIDTH (DWIDTH),
        .DEPTH  (DEPTH),
        .IW     (IW)
    ) u_array (
        .clk   (clk),
        .we    (arr_we),
        .waddr (i_addr[IW-1:0]),
        .wdata (i_wdata),
        .re    (arr_re),
        .raddr (arr_raddr),
        .rdata (arr_rdata)
    );

endmodule

// File: doc/sram_responder.md
Name: sram_responder

Overview:
Memory-side responder for the basic-computer datapath's memory bus. It accepts the datapath's level-held read/write requests (12-bit address, 16-bit data), serves them from an internal word-addressed SRAM array after a programmable number of wait states, and returns read data with a one-cycle valid strobe and a one-cycle write acknowledge. It sits between the datapath and the storage. It is the single place where read/write arbitration and access timing are decided.

Parameters:
DWIDTH, 16, data word width
AWIDTH, 12, address width
DEPTH, 4096, implemented words (must be ≤ 2**AWIDTH)
RD_WAIT, 1, wait-state cycles inserted before a read is sampled from the array (0..7)

Ports:
clk  in  1  single clock, rising edge
i_rst_n  in  1  reset, asynchronous assert, active-low
i_read  in  1  read request, level; may be held high continuously
i_write  in  1  write request, level
i_addr  in  AWIDTH  request address
i_wdata  in  DWIDTH  write data
o_rdata  out  DWIDTH  read data; holds last read value
o_rvalid  out  1  one-cycle pulse, o_rdata valid
o_wack  out  1  one-cycle pulse, write committed
o_busy  out  1  high when not IDLE; requests are ignored while high
o_err  out  1  one-cycle pulse, out-of-range access

Behaviour:
- Reset values: o_rdata=0, o_rvalid=0, o_wack=0, o_busy=0, o_err=0, state=IDLE, wait counter=0. Array contents are not reset.
- States: IDLE, RWAIT, RRESP, WRESP. o_busy = (state != IDLE), registered.
- Acceptance: at a rising edge in IDLE with i_read|i_write=1, latch i_addr and the operation.
- Both requests high at acceptance: write wins. The read is dropped, not queued.
- Write accepted at edge N: array[addr] is written at edge N. Next state is WRESP. o_wack is high for the cycle after N, then the block returns to IDLE.
- Read accepted at edge N:
  - RD_WAIT=0: go to RRESP. The array is read at edge N.
  - RD_WAIT=k>0: go to RWAIT with the counter loaded to k−1. Decrement each cycle. At the edge where the counter reads 0, read the array and go to RRESP.
  - In RRESP, o_rvalid=1 for exactly one cycle with o_rdata updated, then IDLE.
  - Read latency is RD_WAIT+1 cycles from the acceptance edge to o_rvalid.
- Requests during RWAIT, RRESP or WRESP are ignored. A still-held level request is re-accepted at the first edge back in IDLE. Each acceptance yields exactly one o_rvalid or o_wack.
- Minimum request spacing: reads RD_WAIT+2 cycles, writes 2 cycles.
- Read-after-write to the same address returns the newly written value.
- Out of range (addr ≥ DEPTH):
  - Read: completes with normal timing, o_rdata=0, o_err pulses together with o_rvalid.
  - Write: array untouched, o_wack and o_err pulse together.
- i_addr/i_wdata changes after acceptance have no effect (operands are latched).
- Reset mid-operation: immediate return to IDLE, all outputs cleared, pending read discarded. A write whose acceptance edge already occurred stays committed.
- Width rules: DWIDTH data is passed unmodified. No sign handling, no partial writes.

Optional Feature:
SRAM_STATS_EN:
- Defined: adds outputs o_rd_cnt[15:0] and o_wr_cnt[15:0]. These count accepted reads and writes, including out-of-range ones, saturate at 16'hFFFF, and are cleared by reset.
- Undefined: the ports and counters are absent and behaviour is otherwise identical.

Decomposition:
- Shared package sram_pkg: DWIDTH/AWIDTH defaults, the state enum (IDLE, RWAIT, RRESP, WRESP), and the RD_WAIT counter width constant.
- One natural sub-module, sram_array: DEPTH×DWIDTH storage with synchronous write enable and synchronous registered read. It is instantiated once; the FSM, range check and stats stay in sram_responder.

Test Plan:
- Write 16'hBEEF to 12'h010 with i_write for 1 cycle, then read 12'h010 with RD_WAIT=1 -> o_wack the cycle after acceptance; o_rvalid 2 cycles after read acceptance with o_rdata=16'hBEEF.
- i_read held high 10 cycles at 12'h003 (holding 16'h1234), RD_WAIT=1 -> o_rvalid every 3 cycles, each with 16'h1234; o_busy high between pulses.
- i_read=i_write=1, addr 12'h020, wdata 16'h00AA -> only o_wack, no o_rvalid; a subsequent read returns 16'h00AA.
- DEPTH=1024, write 16'h5555 to 12'h400 then read 12'h400 -> o_wack+o_err; then o_rvalid+o_err with o_rdata=0; array[0] unchanged.
- RD_WAIT=3, read accepted, i_rst_n low during RWAIT -> outputs 0 immediately; no o_rvalid after release; memory contents intact.
- With SRAM_STATS_EN, 3 reads and 2 writes -> o_rd_cnt=3, o_wr_cnt=2; after 65540 writes, o_wr_cnt=16'hFFFF.
